// File: rtl/stream_uart_pkg.sv
// Shared types and defaults for the stream_uart block: the TX/RX state
// encoding and the default serial bit period.
package stream_uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

endpackage

// File: rtl/stream_uart_rx_fifo.sv
// Show-ahead receive buffer for stream_uart. A push while full is dropped
// unless a pop happens in the same cycle, in which case both are accepted.
module stream_uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o     = (r_count == (AW+1)'(DEPTH));
  assign empty_o    = (r_count == '0);
  assign w_do_pop   = pop_i && !empty_o;
  assign w_do_push  = push_i && (!full_o || w_do_pop);
  assign pop_data_o = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/stream_uart.sv
// Byte-stream <-> UART bridge (8 data bits, 1 stop bit, LSB first).
// Define STREAM_UART_PARITY_EN to add an even parity bit to both directions.
module stream_uart
  import stream_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       uart_tx_o,
  input  logic       uart_rx_i,
  output logic       rx_frame_err_o,
  output logic       rx_overrun_o,
  output logic       rx_parity_err_o
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  uart_state_t   r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]    r_tx_bit, w_tx_bit_nxt;
  logic [7:0]    r_tx_shift, w_tx_shift_nxt;
  logic          r_tx_line, w_tx_line_nxt;
  logic          w_tx_done;
`ifdef STREAM_UART_PARITY_EN
  logic          r_tx_par, w_tx_par_nxt;
`endif

  assign w_tx_done  = (r_tx_cnt == CNT_MAX);
  assign in_ready_o = (r_tx_state == IDLE);
  assign uart_tx_o  = r_tx_line;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = w_tx_done ? '0 : r_tx_cnt + 1'b1;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_line_nxt  = r_tx_line;
`ifdef STREAM_UART_PARITY_EN
    w_tx_par_nxt   = r_tx_par;
`endif
    case (r_tx_state)
      IDLE: begin
        w_tx_cnt_nxt  = '0;
        w_tx_line_nxt = 1'b1;
        if (in_valid_i) begin
          w_tx_state_nxt = START;
          w_tx_shift_nxt = in_data_i;
          w_tx_line_nxt  = 1'b0;
`ifdef STREAM_UART_PARITY_EN
          w_tx_par_nxt   = ^in_data_i;
`endif
        end
      end
      START: if (w_tx_done) begin
        w_tx_state_nxt = DATA;
        w_tx_bit_nxt   = '0;
        w_tx_line_nxt  = r_tx_shift[0];
      end
      DATA: if (w_tx_done) begin
        w_tx_shift_nxt = r_tx_shift >> 1;
        w_tx_line_nxt  = r_tx_shift[1];
        w_tx_bit_nxt   = r_tx_bit + 1'b1;
        if (r_tx_bit == 3'd7) begin
`ifdef STREAM_UART_PARITY_EN
          w_tx_state_nxt = PARITY;
          w_tx_line_nxt  = r_tx_par;
`else
          w_tx_state_nxt = STOP;
          w_tx_line_nxt  = 1'b1;
`endif
        end
      end
`ifdef STREAM_UART_PARITY_EN
      PARITY: if (w_tx_done) begin
        w_tx_state_nxt = STOP;
        w_tx_line_nxt  = 1'b1;
      end
`endif
      STOP: if (w_tx_done) begin
        w_tx_state_nxt = IDLE;
        w_tx_line_nxt  = 1'b1;
      end
      default: begin
        w_tx_state_nxt = IDLE;
        w_tx_line_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_tx_state <= IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
`ifdef STREAM_UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_line  <= w_tx_line_nxt;
`ifdef STREAM_UART_PARITY_EN
      r_tx_par   <= w_tx_par_nxt;
`endif
    end
  end

  // Receive path: r_rx_prev holds the previous synchronized level so a start
  // edge is only seen after the line has been high, including after a frame error.
  logic [1:0]    r_sync;
  logic          r_rx_prev;
  logic          w_rx;
  uart_state_t   r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]    r_rx_bit, w_rx_bit_nxt;
  logic [7:0]    r_rx_shift, w_rx_shift_nxt;
  logic          w_rx_done;
  logic          w_push;
  logic          w_frame_err;
  logic          w_full;
  logic          w_empty;

  assign w_rx      = r_sync[1];
  assign w_rx_done = (r_rx_cnt == CNT_MAX);

`ifdef STREAM_UART_PARITY_EN
  logic w_parity_err;
  assign rx_parity_err_o = w_parity_err;
`else
  assign rx_parity_err_o = 1'b0;
`endif

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = w_rx_done ? '0 : r_rx_cnt + 1'b1;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_push         = 1'b0;
    w_frame_err    = 1'b0;
`ifdef STREAM_UART_PARITY_EN
    w_parity_err   = 1'b0;
`endif
    case (r_rx_state)
      IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_prev && !w_rx) w_rx_state_nxt = START;
      end
      START: if (r_rx_cnt == CNT_HALF) begin
        w_rx_cnt_nxt   = '0;
        w_rx_bit_nxt   = '0;
        w_rx_state_nxt = w_rx ? IDLE : DATA;
      end
      DATA: if (w_rx_done) begin
        w_rx_shift_nxt = {w_rx, r_rx_shift[7:1]};
        w_rx_bit_nxt   = r_rx_bit + 1'b1;
        if (r_rx_bit == 3'd7) begin
`ifdef STREAM_UART_PARITY_EN
          w_rx_state_nxt = PARITY;
`else
          w_rx_state_nxt = STOP;
`endif
        end
      end
`ifdef STREAM_UART_PARITY_EN
      PARITY: if (w_rx_done) begin
        if ((^r_rx_shift) != w_rx) begin
          w_parity_err   = 1'b1;
          w_rx_state_nxt = IDLE;
        end else begin
          w_rx_state_nxt = STOP;
        end
      end
`endif
      STOP: if (w_rx_done) begin
        w_rx_state_nxt = IDLE;
        w_push         = w_rx;
        w_frame_err    = !w_rx;
      end
      default: w_rx_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync     <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_rx_state <= IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_sync     <= {r_sync[0], uart_rx_i};
      r_rx_prev  <= w_rx;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  stream_uart_rx_fifo #(
    .DEPTH(RX_FIFO_DEPTH),
    .WIDTH(8)
  ) u_rx_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .push_i     (w_push),
    .push_data_i(r_rx_shift),
    .pop_i      (out_ready_i),
    .pop_data_o (out_data_o),
    .full_o     (w_full),
    .empty_o    (w_empty)
  );

  assign out_valid_o    = !w_empty;
  assign rx_frame_err_o = w_frame_err;
  assign rx_overrun_o   = w_push && w_full && !out_ready_i;

endmodule

// File: tb/tb_stream_uart.sv
// Directed bench for stream_uart at CLKS_PER_BIT=4, RX_FIFO_DEPTH=4.
// Covers TX framing, RX receive/backpressure, overrun, frame error, glitch and reset abort.
module tb_stream_uart;

  localparam int CPB = 4;
`ifdef STREAM_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       uart_tx;
  logic       uart_rx;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int n_vec = 0;
  int n_err = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_perr = 0;

  always #5 clk = ~clk;

  stream_uart #(
    .CLKS_PER_BIT (CPB),
    .RX_FIFO_DEPTH(4)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .out_data_o     (out_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .uart_tx_o      (uart_tx),
    .uart_rx_i      (uart_rx),
    .rx_frame_err_o (frame_err),
    .rx_overrun_o   (overrun),
    .rx_parity_err_o(parity_err)
  );

  always @(posedge clk) begin
    if (frame_err)  n_ferr <= n_ferr + 1;
    if (overrun)    n_ovr  <= n_ovr + 1;
    if (parity_err) n_perr <= n_perr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake one byte and check every cycle of the serial frame.
  task automatic tx_frame(input logic [7:0] d);
    logic [NB-1:0] f;
    f       = '0;
    f[0]    = 1'b0;
    f[8:1]  = d;
`ifdef STREAM_UART_PARITY_EN
    f[9]    = ^d;
`endif
    f[NB-1] = 1'b1;
    chk("tx_ready_idle", in_ready, 1);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < NB * CPB; k++) begin
      chk("tx_line", uart_tx, f[k / CPB]);
      chk("tx_busy", in_ready, 0);
      @(negedge clk);
    end
    chk("tx_ready_done", in_ready, 1);
  endtask

  // Drive one serial frame; returns on the negedge inside the stop-sample cycle.
  task automatic send_rx(input logic [7:0] d, input logic stop_b, input logic flip_par);
    logic [NB-1:0] f;
    f       = '0;
    f[0]    = 1'b0;
    f[8:1]  = d;
`ifdef STREAM_UART_PARITY_EN
    f[9]    = (^d) ^ flip_par;
`else
    f[0]    = flip_par & 1'b0;
`endif
    f[NB-1] = stop_b;
    for (int i = 0; i < NB; i++) begin
      uart_rx = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  initial begin
    int base;
    rstn      = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    uart_rx   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_line", uart_tx, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_parity_err", parity_err, 0);
    rstn = 1'b1;
    @(negedge clk);

    tx_frame(8'hA5);

    send_rx(8'h3C, 1'b1, 1'b0);
    chk("rx_stop_no_ferr", frame_err, 0);
    chk("rx_not_yet_valid", out_valid, 0);
    @(negedge clk);
    chk("rx_valid", out_valid, 1);
    chk("rx_data", out_data, 8'h3C);
    repeat (5) @(negedge clk);
    chk("rx_held_valid", out_valid, 1);
    chk("rx_held_data", out_data, 8'h3C);
    out_ready = 1'b1;
    @(negedge clk);
    chk("rx_popped", out_valid, 0);
    out_ready = 1'b0;

    base = n_ovr;
    for (int b = 1; b <= 5; b++) begin
      send_rx(8'(b), 1'b1, 1'b0);
      chk("ovr_pulse", overrun, (b == 5) ? 1 : 0);
    end
    @(negedge clk);
    chk("ovr_count", n_ovr - base, 1);
    for (int b = 1; b <= 4; b++) begin
      chk("ovr_valid", out_valid, 1);
      chk("ovr_data", out_data, b);
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("ovr_drained", out_valid, 0);

    base = n_ferr;
    send_rx(8'h55, 1'b0, 1'b0);
    chk("ferr_pulse", frame_err, 1);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("ferr_count", n_ferr - base, 1);
    chk("ferr_no_push", out_valid, 0);

    base = n_ferr + n_ovr + n_perr;
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (6 * CPB) @(negedge clk);
    chk("glitch_no_valid", out_valid, 0);
    chk("glitch_no_err", n_ferr + n_ovr + n_perr - base, 0);
    send_rx(8'h81, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_glitch_valid", out_valid, 1);
    chk("post_glitch_data", out_data, 8'h81);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_glitch_pop", out_valid, 0);

    in_data  = 8'hFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_tx_start_bit", uart_tx, 0);
    chk("mid_tx_busy", in_ready, 0);
    rstn = 1'b0;
    #1;
    chk("abort_tx_line", uart_tx, 1);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    tx_frame(8'h00);

`ifdef STREAM_UART_PARITY_EN
    tx_frame(8'h01);
    base = n_perr;
    send_rx(8'h03, 1'b1, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    chk("perr_count", n_perr - base, 1);
    chk("perr_no_push", out_valid, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
